// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM that drives the ALU datapath.
// It takes one request at a time, puts operand A into the ALU input buffer and
// operand B straight into the ALU, then writes the result back and reports
// completion. It also sequences the dedicated PC-increment operation.
module alu_sequencer #(
    parameter int unsigned REG_ADDR_W = 4,
    parameter int unsigned PC_INDEX   = 15
) (
    input  logic                  clk,
    input  logic                  reset_b,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_pc_inc,
    input  logic                  req_no_wb,
    input  logic [3:0]            req_op_code,
    input  logic [4:0]            req_shift,
    input  logic                  req_carry_in,
    input  logic [REG_ADDR_W-1:0] req_src_a,
    input  logic [REG_ADDR_W-1:0] req_src_b,
    input  logic [REG_ADDR_W-1:0] req_dst,
    input  logic                  error_detect,
    output logic [REG_ADDR_W-1:0] bus_src_sel,
    output logic                  bus_src_alu,
    output logic                  input_buffer_load,
    output logic                  output_buffer_load,
    output logic                  pc_update_control,
    output logic                  forced_add,
    output logic [3:0]            op_code,
    output logic [4:0]            shift,
    output logic                  carry_in,
    output logic                  reg_write_en,
    output logic [REG_ADDR_W-1:0] reg_write_addr,
    output logic                  done_valid,
    output logic                  done_error
);

    localparam logic [REG_ADDR_W-1:0] PcAddr = REG_ADDR_W'(PC_INDEX);

    typedef enum logic [2:0] {
        StIdle,
        StLoadA,
        StExec,
        StPcExec,
        StWb,
        StDone
    } state_t;

    state_t state_q, state_d;

    logic                  pc_inc_q;
    logic                  no_wb_q;
    logic [3:0]            op_code_q;
    logic [4:0]            shift_q;
    logic                  carry_in_q;
    logic [REG_ADDR_W-1:0] src_a_q;
    logic [REG_ADDR_W-1:0] src_b_q;
    logic [REG_ADDR_W-1:0] dst_q;

    logic accept;

    assign accept = req_valid && req_ready;

    // State register.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request holding register, loaded only on the accept edge so that fields
    // presented while busy never bleed into the running operation.
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            pc_inc_q   <= 1'b0;
            no_wb_q    <= 1'b0;
            op_code_q  <= '0;
            shift_q    <= '0;
            carry_in_q <= 1'b0;
            src_a_q    <= '0;
            src_b_q    <= '0;
            dst_q      <= '0;
        end else if (accept) begin
            pc_inc_q   <= req_pc_inc;
            no_wb_q    <= req_no_wb;
            op_code_q  <= req_op_code;
            shift_q    <= req_shift;
            carry_in_q <= req_carry_in;
            src_a_q    <= req_src_a;
            src_b_q    <= req_src_b;
            dst_q      <= req_dst;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = req_pc_inc ? StPcExec : StLoadA;
                end
            end
            StLoadA:  state_d = StExec;
            StExec:   state_d = no_wb_q ? StDone : StWb;
            StPcExec: state_d = StWb;
            StWb:     state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Moore output decode from state and holding register.
    always_comb begin
        req_ready          = 1'b0;
        bus_src_sel        = '0;
        bus_src_alu        = 1'b0;
        input_buffer_load  = 1'b0;
        output_buffer_load = 1'b0;
        pc_update_control  = 1'b0;
        forced_add         = 1'b0;
        op_code            = '0;
        shift              = '0;
        carry_in           = 1'b0;
        reg_write_en       = 1'b0;
        reg_write_addr     = '0;
        done_valid         = 1'b0;
        done_error         = 1'b0;
        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
            end
            StLoadA: begin
                bus_src_sel       = src_a_q;
                input_buffer_load = 1'b1;
            end
            StExec: begin
                bus_src_sel        = src_b_q;
                output_buffer_load = 1'b1;
                op_code            = op_code_q;
                shift              = shift_q;
                carry_in           = carry_in_q;
            end
            StPcExec: begin
                bus_src_sel        = PcAddr;
                pc_update_control  = 1'b1;
                forced_add         = 1'b1;
                output_buffer_load = 1'b1;
            end
            StWb: begin
                bus_src_alu    = 1'b1;
                reg_write_addr = pc_inc_q ? PcAddr : dst_q;
                // error_detect already holds the flag of the result being written.
                reg_write_en   = ~error_detect;
            end
            StDone: begin
                done_valid = 1'b1;
                done_error = error_detect;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule
